// File: rtl/audio_pkg.sv
// Shared types and constants for the audio playback path.
package audio_pkg;

  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned WORD_W       = 32;
  localparam logic [3:0]  FLASH_BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_HALF2     = 2'd3
  } seq_state_t;

  // One 32-bit flash word carries two 16-bit samples; upper=1 selects bits [31:16].
  function automatic logic [SAMPLE_W-1:0] pick_half(input logic [WORD_W-1:0] word,
                                                    input logic              upper);
    return upper ? word[WORD_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/timeout_ctr.sv
// Saturating wait counter; done_o flags the enabled cycle on which the count reaches TERMINAL.
module timeout_ctr #(
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned W    = (TERMINAL < 2) ? 1 : $clog2(TERMINAL + 1);
  localparam logic [W-1:0] TC   = W'(TERMINAL);
  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sample_sequencer.sv
// Fetches one 32-bit flash word per two audio ticks and plays it out as two 16-bit samples.
module sample_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                playpause,
  input  logic                dir,
  output logic                flash_read,
  input  logic                flash_waitrequest,
  input  logic [WORD_W-1:0]   flash_readdata,
  input  logic                flash_readdatavalid,
  output logic [3:0]          flash_byteenable,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                addr_adv,
  output logic                busy,
  output logic                timeout_err,
  output logic                tick_miss
);

  seq_state_t          state_q, state_d;
  logic                dir_q, dir_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                read_q, read_d;
  logic                valid_q, valid_d;
  logic                adv_q, adv_d;
  logic                busy_q, busy_d;
  logic                terr_q, terr_d;
  logic                tmiss_q, tmiss_d;
  logic                to_done;

  timeout_ctr #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear_i(state_q != ST_WAIT_DATA),
    .en_i   (state_q == ST_WAIT_DATA),
    .done_o (to_done)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    word_d   = word_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    adv_d    = 1'b0;
    terr_d   = terr_q;
    tmiss_d  = tmiss_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tick && playpause) begin
          state_d = ST_REQ;
          dir_d   = dir;
        end
      end
      ST_REQ: begin
        if (tick) tmiss_d = 1'b1;
        if (!flash_waitrequest) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (tick) tmiss_d = 1'b1;
        // Data arriving on the terminal-count cycle takes priority over the timeout.
        if (flash_readdatavalid) begin
          word_d   = flash_readdata;
          sample_d = pick_half(flash_readdata, ~dir_q);
          valid_d  = 1'b1;
          state_d  = ST_HALF2;
        end else if (to_done) begin
          sample_d = '0;
          valid_d  = 1'b1;
          adv_d    = 1'b1;
          terr_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_HALF2: begin
        if (tick && playpause) begin
          sample_d = pick_half(word_q, dir_q);
          valid_d  = 1'b1;
          adv_d    = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    read_d = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b1;
      word_q   <= '0;
      sample_q <= '0;
      read_q   <= 1'b0;
      valid_q  <= 1'b0;
      adv_q    <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      tmiss_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      word_q   <= word_d;
      sample_q <= sample_d;
      read_q   <= read_d;
      valid_q  <= valid_d;
      adv_q    <= adv_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      tmiss_q  <= tmiss_d;
    end
  end

  assign flash_read       = read_q;
  assign flash_byteenable = FLASH_BE_ALL;
  assign sample           = sample_q;
  assign sample_valid     = valid_q;
  assign addr_adv         = adv_q;
  assign busy             = busy_q;
  assign timeout_err      = terr_q;
  assign tick_miss        = tmiss_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: per-cycle vector table plus hand-written corner sequences.
module tb_sample_sequencer;

  typedef struct packed {
    logic        tick;
    logic        pp;
    logic        dir;
    logic        wr;
    logic        rdv;
    logic [31:0] rd;
  } ins_t;

  typedef struct packed {
    logic        fr;
    logic [15:0] s;
    logic        sv;
    logic        adv;
    logic        busy;
    logic        terr;
    logic        tm;
  } outs_t;

  typedef struct {
    ins_t  i;
    outs_t o;
  } vec_t;

  localparam int NV = 26;

  logic        clk;
  logic        rst;
  logic        tick, playpause, dir;
  logic        flash_read, flash_waitrequest, flash_readdatavalid;
  logic [31:0] flash_readdata;
  logic [3:0]  flash_byteenable;
  logic [15:0] sample;
  logic        sample_valid, addr_adv, busy, timeout_err, tick_miss;

  int nchecks = 0;
  int nerrors = 0;
  vec_t vecs[NV];
  outs_t act;

  sample_sequencer #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .tick               (tick),
    .playpause          (playpause),
    .dir                (dir),
    .flash_read         (flash_read),
    .flash_waitrequest  (flash_waitrequest),
    .flash_readdata     (flash_readdata),
    .flash_readdatavalid(flash_readdatavalid),
    .flash_byteenable   (flash_byteenable),
    .sample             (sample),
    .sample_valid       (sample_valid),
    .addr_adv           (addr_adv),
    .busy               (busy),
    .timeout_err        (timeout_err),
    .tick_miss          (tick_miss)
  );

  assign act = '{fr: flash_read, s: sample, sv: sample_valid, adv: addr_adv,
                 busy: busy, terr: timeout_err, tm: tick_miss};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ins_t mi(logic t, logic pp, logic d, logic wr, logic rdv, logic [31:0] rd);
    return '{tick: t, pp: pp, dir: d, wr: wr, rdv: rdv, rd: rd};
  endfunction

  function automatic outs_t mo(logic fr, logic [15:0] s, logic sv, logic adv,
                               logic b, logic te, logic tm);
    return '{fr: fr, s: s, sv: sv, adv: adv, busy: b, terr: te, tm: tm};
  endfunction

  task automatic drive(input ins_t in);
    @(negedge clk);
    tick                = in.tick;
    playpause           = in.pp;
    dir                 = in.dir;
    flash_waitrequest   = in.wr;
    flash_readdatavalid = in.rdv;
    flash_readdata      = in.rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input outs_t exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got fr=%b sample=%h sv=%b adv=%b busy=%b terr=%b tmiss=%b, expected fr=%b sample=%h sv=%b adv=%b busy=%b terr=%b tmiss=%b",
               name, act.fr, act.s, act.sv, act.adv, act.busy, act.terr, act.tm,
               exp.fr, exp.s, exp.sv, exp.adv, exp.busy, exp.terr, exp.tm);
    end
  endtask

  initial begin
    // Forward word: dir=1, two stalled cycles, then data.
    vecs[0]  = '{mi(1,1,1,1,0,0),            mo(1,16'h0000,0,0,1,0,0)};
    vecs[1]  = '{mi(0,1,1,1,0,0),            mo(1,16'h0000,0,0,1,0,0)};
    vecs[2]  = '{mi(0,1,1,1,0,0),            mo(1,16'h0000,0,0,1,0,0)};
    vecs[3]  = '{mi(0,1,1,0,0,0),            mo(0,16'h0000,0,0,1,0,0)};
    vecs[4]  = '{mi(0,1,1,1,1,32'hBEEF1234), mo(0,16'h1234,1,0,1,0,0)};
    vecs[5]  = '{mi(0,1,1,1,0,0),            mo(0,16'h1234,0,0,1,0,0)};
    vecs[6]  = '{mi(1,1,1,1,0,0),            mo(0,16'hBEEF,1,1,0,0,0)};
    vecs[7]  = '{mi(0,1,1,1,0,0),            mo(0,16'hBEEF,0,0,0,0,0)};
    // Reverse word; dir flips back to 1 after REQ entry and must not matter.
    vecs[8]  = '{mi(1,1,0,1,0,0),            mo(1,16'hBEEF,0,0,1,0,0)};
    vecs[9]  = '{mi(0,1,1,0,0,0),            mo(0,16'hBEEF,0,0,1,0,0)};
    vecs[10] = '{mi(0,1,1,1,1,32'hBEEF1234), mo(0,16'hBEEF,1,0,1,0,0)};
    vecs[11] = '{mi(1,1,1,1,0,0),            mo(0,16'h1234,1,1,0,0,0)};
    vecs[12] = '{mi(0,1,1,1,0,0),            mo(0,16'h1234,0,0,0,0,0)};
    // Paused tick in IDLE is ignored.
    vecs[13] = '{mi(1,0,1,1,0,0),            mo(0,16'h1234,0,0,0,0,0)};
    // Tick in REQ/WAIT_DATA, pause during read, pause in HALF2 with 5 ticks.
    vecs[14] = '{mi(1,1,1,1,0,0),            mo(1,16'h1234,0,0,1,0,0)};
    vecs[15] = '{mi(1,1,1,1,0,0),            mo(1,16'h1234,0,0,1,0,1)};
    vecs[16] = '{mi(0,0,1,0,0,0),            mo(0,16'h1234,0,0,1,0,1)};
    vecs[17] = '{mi(1,0,1,1,1,32'hCAFE0001), mo(0,16'h0001,1,0,1,0,1)};
    for (int k = 18; k < 23; k++)
      vecs[k] = '{mi(1,0,1,1,0,0),           mo(0,16'h0001,0,0,1,0,1)};
    vecs[23] = '{mi(0,1,1,1,0,0),            mo(0,16'h0001,0,0,1,0,1)};
    vecs[24] = '{mi(1,1,1,1,0,0),            mo(0,16'hCAFE,1,1,0,0,1)};
    // readdatavalid in IDLE is ignored.
    vecs[25] = '{mi(0,1,1,1,1,32'h11112222), mo(0,16'hCAFE,0,0,0,0,1)};

    rst = 1'b1;
    tick = 1'b0; playpause = 1'b0; dir = 1'b1;
    flash_waitrequest = 1'b1; flash_readdatavalid = 1'b0; flash_readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", mo(0,16'h0000,0,0,0,0,0));
    nchecks++;
    if (flash_byteenable !== 4'hF) begin
      nerrors++;
      $display("FAIL byteenable: got %h, expected f", flash_byteenable);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].i);
      chk($sformatf("vec%0d", k), vecs[k].o);
    end

    // Data on the terminal-count cycle wins over the timeout.
    drive(mi(1,1,1,1,0,0));
    chk("dw_req", mo(1,16'hCAFE,0,0,1,0,1));
    drive(mi(0,1,1,0,0,0));
    chk("dw_wait", mo(0,16'hCAFE,0,0,1,0,1));
    for (int k = 0; k < 7; k++) begin
      drive(mi(0,1,1,1,0,0));
      chk($sformatf("dw_wait%0d", k + 1), mo(0,16'hCAFE,0,0,1,0,1));
    end
    drive(mi(0,1,1,1,1,32'h5555AAAA));
    chk("dw_data", mo(0,16'hAAAA,1,0,1,0,1));
    drive(mi(1,1,1,1,0,0));
    chk("dw_half2", mo(0,16'h5555,1,1,0,0,1));

    // No data at all: timeout after 8 WAIT_DATA cycles.
    drive(mi(1,1,1,1,0,0));
    chk("to_req", mo(1,16'h5555,0,0,1,0,1));
    drive(mi(0,1,1,0,0,0));
    chk("to_wait", mo(0,16'h5555,0,0,1,0,1));
    for (int k = 0; k < 7; k++) begin
      drive(mi(0,1,1,1,0,0));
      chk($sformatf("to_wait%0d", k + 1), mo(0,16'h5555,0,0,1,0,1));
    end
    drive(mi(0,1,1,1,0,0));
    chk("to_fire", mo(0,16'h0000,1,1,0,1,1));
    drive(mi(0,1,1,1,1,32'h77778888));
    chk("to_sticky", mo(0,16'h0000,0,0,0,1,1));

    // Asynchronous reset in WAIT_DATA, then a late readdatavalid.
    drive(mi(1,1,1,1,0,0));
    chk("rst_req", mo(1,16'h0000,0,0,1,1,1));
    drive(mi(0,1,1,0,0,0));
    chk("rst_wait", mo(0,16'h0000,0,0,1,1,1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", mo(0,16'h0000,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b0;
    drive(mi(0,1,1,1,1,32'hDEADBEEF));
    chk("rst_late_rdv", mo(0,16'h0000,0,0,0,0,0));
    drive(mi(0,1,1,1,0,0));
    chk("rst_idle", mo(0,16'h0000,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
